// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Valid/ready pipeline stage register with optional 2-entry
//               skid buffer, synchronous flush and bubble (NOP) insertion.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}},
    parameter int                SKID    = 1
) (
    input  logic              clock,
    input  logic              clr_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_nop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_nop,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_head_data, w_head_data_nxt;
    logic              r_head_nop,  w_head_nop_nxt;
    logic [DATA_W-1:0] r_skid_data, w_skid_data_nxt;
    logic              r_skid_nop,  w_skid_nop_nxt;
    logic              r_out_valid;
    logic              w_accept;
    logic              w_release;

    assign w_accept  = in_valid & in_ready;
    assign w_release = r_out_valid & out_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_head_data_nxt = r_head_data;
        w_head_nop_nxt  = r_head_nop;
        w_skid_data_nxt = r_skid_data;
        w_skid_nop_nxt  = r_skid_nop;
        if (flush) begin
            w_state_nxt     = ST_EMPTY;
            w_head_data_nxt = NOP_VAL;
            w_head_nop_nxt  = 1'b1;
            w_skid_data_nxt = NOP_VAL;
            w_skid_nop_nxt  = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt     = ST_ONE;
                        w_head_data_nxt = in_data;
                        w_head_nop_nxt  = in_nop;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_release) begin
                        w_head_data_nxt = in_data;
                        w_head_nop_nxt  = in_nop;
                    end else if (w_accept && (SKID != 0)) begin
                        w_state_nxt     = ST_TWO;
                        w_skid_data_nxt = in_data;
                        w_skid_nop_nxt  = in_nop;
                    end else if (w_release) begin
                        // Head goes back to the bubble encoding when emptied
                        w_state_nxt     = ST_EMPTY;
                        w_head_data_nxt = NOP_VAL;
                        w_head_nop_nxt  = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (w_release) begin
                        w_state_nxt     = ST_ONE;
                        w_head_data_nxt = r_skid_data;
                        w_head_nop_nxt  = r_skid_nop;
                        w_skid_data_nxt = NOP_VAL;
                        w_skid_nop_nxt  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt     = ST_EMPTY;
                    w_head_data_nxt = NOP_VAL;
                    w_head_nop_nxt  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            r_state     <= ST_EMPTY;
            r_head_data <= NOP_VAL;
            r_head_nop  <= 1'b1;
            r_skid_data <= NOP_VAL;
            r_skid_nop  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_head_data <= w_head_data_nxt;
            r_head_nop  <= w_head_nop_nxt;
            r_skid_data <= w_skid_data_nxt;
            r_skid_nop  <= w_skid_nop_nxt;
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            // Registered ready: no combinational path from out_ready
            logic r_in_ready;
            always_ff @(posedge clock or negedge clr_n) begin
                if (!clr_n) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= (w_state_nxt != ST_TWO);
                end
            end
            assign in_ready = r_in_ready;
        end else begin : g_single
            assign in_ready = out_ready | ~r_out_valid;
        end
    endgenerate

    assign out_valid = r_out_valid;
    assign out_data  = r_head_data;
    assign out_nop   = r_head_nop;
    assign occupancy = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_skid
// Description : Directed self-checking bench for pipe_stage_skid (SKID=1 and 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

    localparam logic [7:0] NOP = 8'hEE;

    logic       clock = 1'b0;
    logic       clr_n = 1'b0;
    int         n_checks = 0;
    int         n_fail   = 0;

    // SKID=1 instance
    logic       flush = 0, in_valid = 0, in_nop = 0, out_ready = 0;
    logic [7:0] in_data = 0;
    logic       in_ready, out_valid, out_nop;
    logic [7:0] out_data;
    logic [1:0] occupancy;

    // SKID=0 instance
    logic       s_flush = 0, s_in_valid = 0, s_in_nop = 0, s_out_ready = 0;
    logic [7:0] s_in_data = 0;
    logic       s_in_ready, s_out_valid, s_out_nop;
    logic [7:0] s_out_data;
    logic [1:0] s_occupancy;

    always #5 clock = ~clock;

    pipe_stage_skid #(.DATA_W(8), .NOP_VAL(NOP), .SKID(1)) dut (
        .clock(clock), .clr_n(clr_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_nop(in_nop),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_nop(out_nop), .occupancy(occupancy)
    );

    pipe_stage_skid #(.DATA_W(8), .NOP_VAL(NOP), .SKID(0)) dut0 (
        .clock(clock), .clr_n(clr_n), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_nop(s_in_nop),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_nop(s_out_nop), .occupancy(s_occupancy)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        step();
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_checks++; if (out_data !== NOP) begin n_fail++; $display("FAIL reset_data got %h want %h", out_data, NOP); end
        n_checks++; if (out_nop !== 1'b1) begin n_fail++; $display("FAIL reset_nop got %b want 1", out_nop); end
        n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", in_ready); end
        #2 clr_n = 1'b1;
        step();
        n_checks++; if (in_ready !== 1'b1 || occupancy !== 2'd0) begin n_fail++; $display("FAIL post_reset got rdy=%b occ=%0d want rdy=1 occ=0", in_ready, occupancy); end
    endtask

    task automatic test_streaming();
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = vals[i]; in_nop = 1'b0;
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== vals[i] || occupancy !== 2'd1 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_%0d got v=%b d=%h occ=%0d rdy=%b want v=1 d=%h occ=1 rdy=1",
                         i, out_valid, out_data, occupancy, in_ready, vals[i]);
            end
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== NOP || out_nop !== 1'b1 || occupancy !== 2'd0) begin
            n_fail++;
            $display("FAIL stream_drain got v=%b d=%h nop=%b occ=%0d want v=0 d=%h nop=1 occ=0",
                     out_valid, out_data, out_nop, occupancy, NOP);
        end
    endtask

    task automatic fill_two(input logic [7:0] a, input logic [7:0] b);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = a; in_nop = 1'b0;
        step();
        in_data = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        fill_two(8'hA1, 8'hA2);
        n_checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 8'hA1 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_full got occ=%0d rdy=%b d=%h v=%b want occ=2 rdy=0 d=a1 v=1",
                     occupancy, in_ready, out_data, out_valid);
        end
        in_valid = 1'b1; in_data = 8'hA9;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (occupancy !== 2'd2 || out_data !== 8'hA1) begin
            n_fail++; $display("FAIL bp_hold got occ=%0d d=%h want occ=2 d=a1", occupancy, out_data);
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if (occupancy !== 2'd1 || out_data !== 8'hA2 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_rel1 got occ=%0d d=%h rdy=%b want occ=1 d=a2 rdy=1", occupancy, out_data, in_ready);
        end
        step();
        n_checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== NOP) begin
            n_fail++; $display("FAIL bp_rel2 got occ=%0d v=%b d=%h want occ=0 v=0 d=%h", occupancy, out_valid, out_data, NOP);
        end
    endtask

    task automatic test_flush();
        fill_two(8'hB1, 8'hB2);
        in_valid = 1'b1; in_data = 8'hB3; flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_nop !== 1'b1 || out_data !== NOP || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush got occ=%0d v=%b nop=%b d=%h rdy=%b want occ=0 v=0 nop=1 d=%h rdy=1",
                     occupancy, out_valid, out_nop, out_data, in_ready, NOP);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0 || out_data !== NOP) begin
                n_fail++; $display("FAIL flush_ghost_%0d got v=%b d=%h want v=0 d=%h", i, out_valid, out_data, NOP);
            end
        end
    endtask

    task automatic test_nop_carry();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'hC0; in_nop = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hC0 || out_nop !== 1'b1) begin
            n_fail++; $display("FAIL nop_c0 got v=%b d=%h nop=%b want v=1 d=c0 nop=1", out_valid, out_data, out_nop);
        end
        in_data = 8'hC1; in_nop = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hC1 || out_nop !== 1'b0) begin
            n_fail++; $display("FAIL nop_c1 got v=%b d=%h nop=%b want v=1 d=c1 nop=0", out_valid, out_data, out_nop);
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || out_nop !== 1'b1) begin
            n_fail++; $display("FAIL nop_drain got v=%b nop=%b want v=0 nop=1", out_valid, out_nop);
        end
    endtask

    task automatic test_reset_midstream();
        fill_two(8'h5A, 8'h5B);
        in_valid = 1'b1; in_data = 8'h5C;
        #2 clr_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== NOP || out_nop !== 1'b1 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid got v=%b d=%h nop=%b occ=%0d rdy=%b want v=0 d=%h nop=1 occ=0 rdy=1",
                     out_valid, out_data, out_nop, occupancy, in_ready, NOP);
        end
        in_valid = 1'b0;
        #1 clr_n = 1'b1;
        step();
        n_checks++;
        if (occupancy !== 2'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_rel got occ=%0d rdy=%b v=%b want occ=0 rdy=1 v=0", occupancy, in_ready, out_valid);
        end
    endtask

    task automatic test_skid0();
        logic [8:0] q[$];
        logic       exp_v, exp_rdy;
        s_out_ready = 1'b0;
        s_in_valid = 1'b1; s_in_data = 8'hD0; s_in_nop = 1'b0;
        step();
        s_in_valid = 1'b0;
        n_checks++;
        if (s_out_valid !== 1'b1 || s_out_data !== 8'hD0 || s_occupancy !== 2'd1 || s_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL s0_hold got v=%b d=%h occ=%0d rdy=%b want v=1 d=d0 occ=1 rdy=0",
                     s_out_valid, s_out_data, s_occupancy, s_in_ready);
        end
        s_in_valid = 1'b1; s_in_data = 8'hD1;
        step();
        n_checks++;
        if (s_occupancy !== 2'd1 || s_out_data !== 8'hD0) begin
            n_fail++; $display("FAIL s0_nooverfill got occ=%0d d=%h want occ=1 d=d0", s_occupancy, s_out_data);
        end
        s_in_valid = 1'b0;
        s_out_ready = 1'b1;
        #1;
        n_checks++;
        if (s_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL s0_comb_ready got %b want 1", s_in_ready);
        end
        step();
        for (int i = 0; i < 300; i++) begin
            s_in_valid  = 1'($urandom_range(0, 1));
            s_out_ready = ($urandom_range(0, 3) != 0);
            s_in_data   = 8'($urandom);
            s_in_nop    = 1'($urandom);
            #1;
            exp_v   = (q.size() != 0);
            exp_rdy = s_out_ready || !exp_v;
            n_checks++;
            if (s_in_ready !== exp_rdy || s_out_valid !== exp_v || s_occupancy !== 2'(q.size())) begin
                n_fail++;
                $display("FAIL s0_rand_ctl_%0d got rdy=%b v=%b occ=%0d want rdy=%b v=%b occ=%0d",
                         i, s_in_ready, s_out_valid, s_occupancy, exp_rdy, exp_v, q.size());
            end
            n_checks++;
            if (exp_v && {s_out_nop, s_out_data} !== q[0]) begin
                n_fail++; $display("FAIL s0_rand_data_%0d got %h want %h", i, {s_out_nop, s_out_data}, q[0]);
            end else if (!exp_v && {s_out_nop, s_out_data} !== {1'b1, NOP}) begin
                n_fail++; $display("FAIL s0_rand_bubble_%0d got %h want %h", i, {s_out_nop, s_out_data}, {1'b1, NOP});
            end
            if (exp_v && s_out_ready) void'(q.pop_front());
            if (s_in_valid && exp_rdy) q.push_back({s_in_nop, s_in_data});
            step();
        end
        s_in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_nop_carry();
        test_reset_midstream();
        test_skid0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
